pool_map_collector: RTL and testbench

Downstream stage of `pool_image_clked`. Accepts the serial stream of pooled values, writes them in raster order into a 1024-entry feature-map buffer, and raises `done` once the full (imgSize/windowSize)² map is stored. The next layer reads the map back through a registered read port. Output dimension is derived on-chip by iterative subtraction, so the block needs no divider.

---
 rtl/pool_map_collector.sv | 151 +++++++++++++++
 tb/tb_pool_map_collector.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_map_collector.sv
// Pooled-sample collector: stores a (imgSize/windowSize)^2 map in raster order.
// Optional POOL_RELU_EN clamps negative samples to zero before they are stored.
module pool_map_collector #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 1024,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0]       imgSize,
    input  logic [15:0]       windowSize,
    input  logic              inValid,
    input  logic [DATA_W-1:0] pooledIn,
    output logic              inReady,
    output logic [15:0]       outDim,
    input  logic [AW-1:0]     rdAddr,
    output logic [DATA_W-1:0] rdData,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIMS,
        S_COLLECT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_win;
    logic [15:0]       r_quot;
    logic [15:0]       r_rem;
    logic [15:0]       r_total;
    logic [15:0]       r_wrPtr;
    logic [15:0]       r_outDim;
    logic [DATA_W-1:0] r_rdData;
    logic [DATA_W-1:0] r_buf [DEPTH];

    logic              w_xfer;
    logic              w_last;
    logic              w_bad_cfg;
    logic              w_fits;
    logic              w_quot_big;
    logic [DATA_W-1:0] w_wdata;

    assign w_xfer     = (r_state == S_COLLECT) && inValid;
    assign w_last     = (r_wrPtr == r_total - 16'd1);
    assign w_bad_cfg  = (windowSize == 16'd0) || (windowSize > imgSize);
    assign w_fits     = (r_rem >= r_win);
    assign w_quot_big = (r_quot > 16'd32);

`ifdef POOL_RELU_EN
    assign w_wdata = pooledIn[DATA_W-1] ? '0 : pooledIn;
`else
    assign w_wdata = pooledIn;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next = w_bad_cfg ? S_ERR : S_DIMS;
                end
            end
            S_DIMS: begin
                if (!enable) begin
                    w_next = S_IDLE;
                end else if (!w_fits) begin
                    w_next = w_quot_big ? S_ERR : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (!enable) begin
                    w_next = S_IDLE;
                end else if (w_xfer && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                if (!enable) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Divider-free quotient: one subtraction of the window per DIMS cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win    <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_total  <= '0;
            r_wrPtr  <= '0;
            r_outDim <= '0;
        end else begin
            if (r_state == S_IDLE && enable) begin
                r_win   <= windowSize;
                r_quot  <= '0;
                r_rem   <= imgSize;
                r_wrPtr <= '0;
            end
            if (r_state == S_DIMS && enable) begin
                if (w_fits) begin
                    r_rem  <= r_rem - r_win;
                    r_quot <= r_quot + 16'd1;
                end else if (!w_quot_big) begin
                    r_outDim <= r_quot;
                    r_total  <= r_quot * r_quot;
                end
            end
            if (w_xfer) begin
                r_wrPtr <= r_wrPtr + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_buf[r_wrPtr[AW-1:0]] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= r_buf[rdAddr];
        end
    end

    assign inReady = (r_state == S_COLLECT);
    assign done    = (r_state == S_DONE);
    assign error   = (r_state == S_ERR);
    assign outDim  = r_outDim;
    assign rdData  = r_rdData;

endmodule

// File: tb/tb_pool_map_collector.sv
// Bench for pool_map_collector: behavioural map model plus directed scenarios.
module tb_pool_map_collector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] imgSize = '0;
    logic [15:0] windowSize = '0;
    logic        inValid = 1'b0;
    logic [15:0] pooledIn = '0;
    logic        inReady;
    logic [15:0] outDim;
    logic [9:0]  rdAddr = '0;
    logic [15:0] rdData;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    pool_map_collector dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .imgSize(imgSize),
        .windowSize(windowSize),
        .inValid(inValid),
        .pooledIn(pooledIn),
        .inReady(inReady),
        .outDim(outDim),
        .rdAddr(rdAddr),
        .rdData(rdData),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] d);
`ifdef POOL_RELU_EN
        return d[15] ? 16'h0000 : d;
`else
        return d;
`endif
    endfunction

    // Model: phase of the transaction, map contents, expected read word.
    typedef enum int {P_IDLE, P_DIMS, P_COL, P_DONE, P_ERR} phase_t;
    phase_t      m_phase = P_IDLE;
    int          m_q = 0;
    int          m_left = 0;
    int          m_total = 0;
    int          m_cnt = 0;
    logic [15:0] m_outdim = '0;
    logic [15:0] m_rd = '0;
    bit          m_rdk = 1'b1;
    logic [15:0] m_mem [1024];
    bit          m_memv [1024];
    bit          m_on = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase  <= P_IDLE;
            m_outdim <= '0;
            m_rd     <= '0;
            m_rdk    <= 1'b1;
        end else begin
            m_rd  <= m_mem[rdAddr];
            m_rdk <= m_memv[rdAddr];
            case (m_phase)
                P_IDLE: if (enable) begin
                    m_cnt <= 0;
                    if (windowSize == 0 || windowSize > imgSize) begin
                        m_phase <= P_ERR;
                    end else begin
                        m_q     <= int'(imgSize / windowSize);
                        m_left  <= int'(imgSize / windowSize) + 1;
                        m_phase <= P_DIMS;
                    end
                end
                P_DIMS: begin
                    if (!enable) m_phase <= P_IDLE;
                    else if (m_left == 1) begin
                        if (m_q > 32) m_phase <= P_ERR;
                        else begin
                            m_outdim <= m_q[15:0];
                            m_total  <= m_q * m_q;
                            m_phase  <= P_COL;
                        end
                    end else m_left <= m_left - 1;
                end
                P_COL: begin
                    if (inValid) begin
                        m_mem[m_cnt]  <= relu(pooledIn);
                        m_memv[m_cnt] <= 1'b1;
                        m_cnt         <= m_cnt + 1;
                    end
                    if (!enable) m_phase <= P_IDLE;
                    else if (inValid && m_cnt + 1 == m_total) m_phase <= P_DONE;
                end
                default: if (!enable) m_phase <= P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("inReady", 32'(inReady), 32'(m_phase == P_COL));
            chk("done", 32'(done), 32'(m_phase == P_DONE));
            chk("error", 32'(error), 32'(m_phase == P_ERR));
            chk("outDim", 32'(outDim), 32'(m_outdim));
            if (m_rdk) chk("rdData", 32'(rdData), 32'(m_rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int lim);
        int n = 0;
        while (!inReady && n < lim) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(inReady), 32'd1);
    endtask

    task automatic send(input logic [15:0] d);
        inValid  = 1'b1;
        pooledIn = d;
        tick();
        inValid  = 1'b0;
    endtask

    task automatic read_chk(input string nm, input logic [9:0] a,
                            input logic [15:0] exp);
        rdAddr = a;
        tick();
        chk(nm, 32'(rdData), 32'(exp));
    endtask

    logic [15:0] v4 [4] = '{16'h0400, 16'hA000, 16'h0400, 16'h0400};
    logic [15:0] w4 [4] = '{16'h0123, 16'h0456, 16'h0789, 16'h7ABC};
    logic [15:0] neg_exp;

    initial begin
`ifdef POOL_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'hA000;
`endif
        // Scenario 1: 10/5 -> 2x2 map
        enable = 1'b1;
        imgSize = 16'd10;
        windowSize = 16'd5;
        tick();
        m_on = 1'b1;
        tick();
        chk("rst_inReady", 32'(inReady), 32'd0);
        chk("rst_outDim", 32'(outDim), 32'd0);
        chk("rst_rdData", 32'(rdData), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        tick();
        chk("dims0", 32'(inReady), 32'd0);
        tick();
        chk("dims1", 32'(inReady), 32'd0);
        tick();
        chk("dims2", 32'(inReady), 32'd0);
        tick();
        chk("collect_ready", 32'(inReady), 32'd1);
        chk("outDim_2", 32'(outDim), 32'd2);
        for (int i = 0; i < 4; i++) begin
            send(v4[i]);
            if (i == 2) chk("done_early", 32'(done), 32'd0);
        end
        chk("done_4", 32'(done), 32'd1);
        chk("ready_off", 32'(inReady), 32'd0);
        read_chk("rd_addr1", 10'd1, neg_exp);

        // Scenario 2: zero window
        enable = 1'b0;
        tick();
        imgSize = 16'd7;
        windowSize = 16'd0;
        enable = 1'b1;
        tick();
        chk("err_w0", 32'(error), 32'd1);
        tick();
        tick();
        chk("err_w0_ready", 32'(inReady), 32'd0);
        enable = 1'b0;
        tick();
        chk("err_clear", 32'(error), 32'd0);

        // Scenario 3: quotient too large
        imgSize = 16'd1024;
        windowSize = 16'd2;
        enable = 1'b1;
        for (int n = 0; n < 600 && !error; n++) tick();
        chk("err_big", 32'(error), 32'd1);
        read_chk("rd_after_err", 10'd1, neg_exp);
        enable = 1'b0;
        tick();

        // Scenario 4: full 32x32 map with gaps
        imgSize = 16'd64;
        windowSize = 16'd2;
        enable = 1'b1;
        wait_ready(100);
        chk("outDim_32", 32'(outDim), 32'd32);
        for (int i = 0; i < 1024; i++) begin
            send(16'(i));
            tick();
        end
        chk("done_1024", 32'(done), 32'd1);
        read_chk("rd_1023", 10'd1023, 16'd1023);
        read_chk("rd_517", 10'd517, 16'd517);

        // Scenario 5: abort after 2 samples, restart
        enable = 1'b0;
        tick();
        imgSize = 16'd10;
        windowSize = 16'd5;
        enable = 1'b1;
        wait_ready(20);
        send(16'h1111);
        send(16'h2222);
        enable = 1'b0;
        tick();
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(inReady), 32'd0);
        enable = 1'b1;
        rdAddr = 10'd0;
        wait_ready(20);
        for (int i = 0; i < 4; i++) send(w4[i]);
        chk("restart_done", 32'(done), 32'd1);
        for (int a = 0; a < 4; a++) read_chk("restart_rd", 10'(a), w4[a]);

        // Scenario 6: asynchronous reset mid-collect
        enable = 1'b0;
        tick();
        enable = 1'b1;
        wait_ready(20);
        send(16'h5555);
        inValid = 1'b1;
        pooledIn = 16'hDEAD;
        reset = 1'b1;
        #1;
        chk("arst_inReady", 32'(inReady), 32'd0);
        chk("arst_outDim", 32'(outDim), 32'd0);
        chk("arst_rdData", 32'(rdData), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_error", 32'(error), 32'd0);
        for (int i = 0; i < 3; i++) begin
            inValid = ~inValid;
            tick();
        end
        inValid = 1'b0;
        enable = 1'b0;
        reset = 1'b0;
        tick();
        read_chk("arst_rd0", 10'd0, 16'h5555);
        read_chk("arst_rd1", 10'd1, 16'h0456);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
